branch_predict_unit: RTL and testbench

- Standalone, parametrised branch-direction and return-address predictor for the in-order RV32 pipeline. It sits beside decode.
- Direction prediction is gshare: PC bits XOR global history, indexing a table of CTR_BITS saturating counters. Returns use a RAS of RAS_DEPTH entries.
- Adds over the prior inline predictor: generic counter width, deep circular RAS with occupancy/valid tracking, and a post-reset table-clear FSM.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/return_addr_stack.sv | 68 ++++++
 rtl/branch_predict_unit.sv | 139 +++++++++++++
 tb/tb_branch_predict_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor.
package bp_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpState_e;

  localparam int unsigned CTR_MAX_BITS = 8;
  typedef logic [CTR_MAX_BITS-1:0] ctrWord_t;

  // Weakly not-taken value for a counter of the given width.
  function automatic ctrWord_t ctrInitVal(input int unsigned bits);
    return ctrWord_t'((32'd1 << (bits - 32'd1)) - 32'd1);
  endfunction

  // Saturating step towards maxVal (up) or towards zero (down).
  function automatic ctrWord_t ctrSat(input ctrWord_t ctr, input ctrWord_t maxVal,
                                      input logic up);
    ctrWord_t res;
    res = ctr;
    if (up && (ctr != maxVal)) begin
      res = ctr + ctrWord_t'(1);
    end else if (!up && (ctr != '0)) begin
      res = ctr - ctrWord_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with occupancy tracking; oldest entry is lost on overflow.
module return_addr_stack
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] pushAddr,
  output logic [31:0] top,
  output logic        valid
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

  logic [31:0]         entries [DEPTH];
  logic [PTR_BITS-1:0] ptr, ptrNext, wrPtr;
  logic [CNT_BITS-1:0] count, countNext;
  logic                wrEn;

  // Push/pop/replace decision; a call+ret pair rewrites the top in place.
  always_comb begin
    ptrNext   = ptr;
    countNext = count;
    wrEn      = 1'b0;
    wrPtr     = ptr;
    if (push && pop) begin
      wrEn = 1'b1;
      if (count == '0) begin
        countNext = CNT_BITS'(1);
      end
    end else if (push) begin
      wrEn    = 1'b1;
      wrPtr   = ptr + PTR_BITS'(1);
      ptrNext = ptr + PTR_BITS'(1);
      if (count != CNT_FULL) begin
        countNext = count + CNT_BITS'(1);
      end
    end else if (pop && (count != '0)) begin
      ptrNext   = ptr - PTR_BITS'(1);
      countNext = count - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      ptr   <= ptrNext;
      count <= countNext;
      if (wrEn) begin
        entries[wrPtr] <= pushAddr;
      end
    end
  end

  assign top   = entries[ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare direction predictor plus return-address stack, with a post-reset table clear.
// Optional: define BP_STATS_EN to add update and mispredict counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned BP_ADDR_BITS = 12,
  parameter int unsigned BH_BITS      = 9,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned RAS_DEPTH    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  output logic                    ready_o,
  input  logic                    lk_valid_i,
  input  logic                    lk_stall_i,
  input  logic [31:0]             lk_pc_i,
  input  logic                    lk_isCall_i,
  input  logic                    lk_isRet_i,
  input  logic [31:0]             lk_retAddr_i,
  output logic                    lk_taken_o,
  output logic [BP_ADDR_BITS-1:0] lk_index_o,
  output logic [31:0]             lk_rasTop_o,
  output logic                    lk_rasValid_o,
  input  logic                    up_valid_i,
  input  logic [BP_ADDR_BITS-1:0] up_index_i,
  input  logic                    up_taken_i,
  input  logic                    up_predicted_i
`ifdef BP_STATS_EN
  ,
  output logic [31:0]             stat_updates_o,
  output logic [31:0]             stat_mispredicts_o
`endif
);

  localparam int unsigned TBL_SIZE = 1 << BP_ADDR_BITS;
  localparam int unsigned PAD_BITS = BP_ADDR_BITS - BH_BITS;
  localparam logic [BP_ADDR_BITS-1:0] IDX_LAST = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctrInitVal(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  bpState_e                state, stateNext;
  logic [BP_ADDR_BITS-1:0] initCnt, initCntNext;
  logic [BH_BITS-1:0]      history, historyNext;
  logic                    readyQ, readyNext;

  logic [CTR_BITS-1:0]     ctrTable [TBL_SIZE];
  logic [BP_ADDR_BITS-1:0] lkIndex;
  logic [CTR_BITS-1:0]     lkCtr, upCtr, upCtrNext;
  logic                    upAccept, rasPush, rasPop;
  logic                    unusedBits;

  assign upAccept = (state == ST_RUN) && up_valid_i;
  assign lkIndex  = lk_pc_i[BP_ADDR_BITS:1] ^ (BP_ADDR_BITS'(history) << PAD_BITS);
  assign lkCtr    = ctrTable[lkIndex];
  assign upCtr    = ctrTable[up_index_i];
  assign upCtrNext = CTR_BITS'(ctrSat(ctrWord_t'(upCtr), ctrWord_t'(CTR_MAX), up_taken_i));

  // Init sweep, run-state history shift and ready flag.
  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    historyNext = history;
    readyNext   = readyQ;
    if (state == ST_INIT) begin
      initCntNext = initCnt + BP_ADDR_BITS'(1);
      if (initCnt == IDX_LAST) begin
        stateNext   = ST_RUN;
        readyNext   = 1'b1;
        initCntNext = '0;
      end
    end else if (up_valid_i) begin
      historyNext = BH_BITS'({up_taken_i, history} >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= ST_INIT;
      initCnt <= '0;
      history <= '0;
      readyQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
      history <= historyNext;
      readyQ  <= readyNext;
    end
  end

  // Table storage is cleared by the init sweep rather than by reset.
  always_ff @(posedge clk_i) begin
    if (state == ST_INIT) begin
      ctrTable[initCnt] <= CTR_INIT;
    end else if (upAccept) begin
      ctrTable[up_index_i] <= upCtrNext;
    end
  end

  assign ready_o    = readyQ;
  assign lk_index_o = lkIndex;
  assign lk_taken_o = (state == ST_RUN) && lkCtr[CTR_BITS-1];

  assign rasPush = lk_valid_i && !lk_stall_i && lk_isCall_i;
  assign rasPop  = lk_valid_i && !lk_stall_i && lk_isRet_i;

  return_addr_stack #(
    .DEPTH(RAS_DEPTH)
  ) uRas (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (rasPush),
    .pop     (rasPop),
    .pushAddr(lk_retAddr_i),
    .top     (lk_rasTop_o),
    .valid   (lk_rasValid_o)
  );

`ifdef BP_STATS_EN
  logic [31:0] statUpdates, statMispredicts;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      statUpdates     <= '0;
      statMispredicts <= '0;
    end else if (upAccept) begin
      statUpdates <= statUpdates + 32'd1;
      if (up_taken_i != up_predicted_i) begin
        statMispredicts <= statMispredicts + 32'd1;
      end
    end
  end

  assign stat_updates_o     = statUpdates;
  assign stat_mispredicts_o = statMispredicts;
`endif

  assign unusedBits = ^{lk_pc_i[31:BP_ADDR_BITS+1], lk_pc_i[0], up_predicted_i};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (12-bit index, 9-bit history, 3-bit counters, 4-entry RAS).
module tb_branch_predict_unit;

  localparam int unsigned AB = 12;
  localparam int unsigned HB = 9;
  localparam int unsigned CB = 3;
  localparam int unsigned RD = 4;
  localparam int unsigned INIT_CYCLES = 1 << AB;

  logic          clk_i;
  logic          reset_i;
  logic          ready_o;
  logic          lk_valid_i, lk_stall_i, lk_isCall_i, lk_isRet_i;
  logic [31:0]   lk_pc_i, lk_retAddr_i;
  logic          lk_taken_o;
  logic [AB-1:0] lk_index_o;
  logic [31:0]   lk_rasTop_o;
  logic          lk_rasValid_o;
  logic          up_valid_i, up_taken_i, up_predicted_i;
  logic [AB-1:0] up_index_i;
`ifdef BP_STATS_EN
  logic [31:0]   stat_updates_o, stat_mispredicts_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [HB-1:0] histModel = '0;

  branch_predict_unit #(
    .BP_ADDR_BITS(AB), .BH_BITS(HB), .CTR_BITS(CB), .RAS_DEPTH(RD)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ready_o(ready_o),
    .lk_valid_i(lk_valid_i), .lk_stall_i(lk_stall_i), .lk_pc_i(lk_pc_i),
    .lk_isCall_i(lk_isCall_i), .lk_isRet_i(lk_isRet_i), .lk_retAddr_i(lk_retAddr_i),
    .lk_taken_o(lk_taken_o), .lk_index_o(lk_index_o), .lk_rasTop_o(lk_rasTop_o),
    .lk_rasValid_o(lk_rasValid_o), .up_valid_i(up_valid_i), .up_index_i(up_index_i),
    .up_taken_i(up_taken_i), .up_predicted_i(up_predicted_i)
`ifdef BP_STATS_EN
    , .stat_updates_o(stat_updates_o), .stat_mispredicts_o(stat_mispredicts_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] pcFor(input logic [AB-1:0] idx, input logic [HB-1:0] h);
    logic [AB-1:0] p;
    p = idx ^ {h, 3'b000};
    return {19'd0, p, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    lk_valid_i = 1'b0; lk_stall_i = 1'b0; lk_isCall_i = 1'b0; lk_isRet_i = 1'b0;
    up_valid_i = 1'b0; up_taken_i = 1'b0; up_predicted_i = 1'b0;
  endtask

  task automatic doUpdate(input logic [AB-1:0] idx, input logic taken, input logic pred);
    up_valid_i = 1'b1; up_index_i = idx; up_taken_i = taken; up_predicted_i = pred;
    tick();
    up_valid_i = 1'b0;
    histModel = {taken, histModel[HB-1:1]};
  endtask

  task automatic rasOp(input logic call, input logic ret, input logic stall, input logic [31:0] addr);
    lk_valid_i = 1'b1; lk_stall_i = stall; lk_isCall_i = call; lk_isRet_i = ret; lk_retAddr_i = addr;
    tick();
    lk_valid_i = 1'b0; lk_stall_i = 1'b0; lk_isCall_i = 1'b0; lk_isRet_i = 1'b0;
  endtask

  task automatic test_reset();
    int badTaken, badReady;
    badTaken = 0; badReady = 0;
    idle(); reset_i = 1'b0; lk_pc_i = '0; up_index_i = '0; lk_retAddr_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL reset_rasValid: got %b expected 0", lk_rasValid_o); end
    checks++; if (lk_rasTop_o !== 32'h0) begin errors++; $display("FAIL reset_rasTop: got %h expected 0", lk_rasTop_o); end
    checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", lk_taken_o); end
    reset_i = 1'b1;
    for (int c = 1; c <= int'(INIT_CYCLES); c++) begin
      idle();
      lk_pc_i = 32'(c) << 1;
      if (c == 5) begin lk_valid_i = 1'b1; lk_isCall_i = 1'b1; lk_retAddr_i = 32'hABC; end
      if (c == 6) begin lk_valid_i = 1'b1; lk_isRet_i = 1'b1; end
      if (c >= 10 && c < 13) begin up_valid_i = 1'b1; up_index_i = 12'h080; up_taken_i = 1'b1; end
      #1 if (lk_taken_o !== 1'b0) badTaken++;
      tick();
      if (c < int'(INIT_CYCLES) && ready_o !== 1'b0) badReady++;
      if (c == 5) begin
        checks++; if (lk_rasTop_o !== 32'hABC || lk_rasValid_o !== 1'b1) begin errors++;
          $display("FAIL init_push: got top=%h valid=%b expected top=abc valid=1", lk_rasTop_o, lk_rasValid_o); end
      end
      if (c == 6) begin
        checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL init_pop: got valid=%b expected 0", lk_rasValid_o); end
      end
      if (c == int'(INIT_CYCLES) - 1) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_early: got %b expected 0 after 4095 cycles", ready_o); end
      end
    end
    idle();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b expected 1 after 4096 cycles", ready_o); end
    checks++; if (badTaken != 0) begin errors++; $display("FAIL init_taken: got %0d taken lookups expected 0", badTaken); end
    checks++; if (badReady != 0) begin errors++; $display("FAIL init_ready: got %0d early ready cycles expected 0", badReady); end
    lk_pc_i = 32'h0; #1;
    checks++; if (lk_index_o !== 12'h000) begin errors++; $display("FAIL init_no_hist: got index %h expected 000", lk_index_o); end
    lk_pc_i = 32'h100; #1;
    checks++; if (lk_index_o !== 12'h080 || lk_taken_o !== 1'b0) begin errors++;
      $display("FAIL run_weak_nt: got index=%h taken=%b expected index=080 taken=0", lk_index_o, lk_taken_o); end
    lk_pc_i = 32'h1FFE; #1;
    checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL run_weak_nt_hi: got %b expected 0", lk_taken_o); end
  endtask

  task automatic test_counter();
    lk_pc_i = pcFor(12'h080, histModel);
    up_valid_i = 1'b1; up_index_i = 12'h080; up_taken_i = 1'b1; up_predicted_i = 1'b0;
    #1;
    checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", lk_taken_o); end
    tick(); up_valid_i = 1'b0; histModel = {1'b1, histModel[HB-1:1]};
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_index_o !== 12'h080 || lk_taken_o !== 1'b1) begin errors++;
      $display("FAIL ctr_first: got index=%h taken=%b expected index=080 taken=1", lk_index_o, lk_taken_o); end
    repeat (4) doUpdate(12'h080, 1'b1, 1'b1);
    repeat (3) doUpdate(12'h080, 1'b0, 1'b1);
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_taken_o !== 1'b1) begin errors++; $display("FAIL ctr_sat_hi: got %b expected 1 (counter 4)", lk_taken_o); end
    doUpdate(12'h080, 1'b0, 1'b1);
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL ctr_down: got %b expected 0 (counter 3)", lk_taken_o); end
    repeat (4) doUpdate(12'h080, 1'b0, 1'b0);
    repeat (3) doUpdate(12'h080, 1'b1, 1'b0);
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL ctr_sat_lo: got %b expected 0 (counter 3)", lk_taken_o); end
    doUpdate(12'h080, 1'b1, 1'b0);
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_index_o !== 12'h080 || lk_taken_o !== 1'b1) begin errors++;
      $display("FAIL ctr_up_again: got index=%h taken=%b expected index=080 taken=1", lk_index_o, lk_taken_o); end
  endtask

  task automatic test_history();
    repeat (6) doUpdate(12'h005, 1'b0, 1'b0);
    doUpdate(12'h005, 1'b1, 1'b0);
    doUpdate(12'h005, 1'b1, 1'b0);
    doUpdate(12'h005, 1'b0, 1'b0);
    lk_pc_i = 32'h0; #1;
    checks++; if (lk_index_o !== 12'h600) begin errors++; $display("FAIL hist_pc0: got %h expected 600", lk_index_o); end
    lk_pc_i = 32'h100; #1;
    checks++; if (lk_index_o !== 12'h680) begin errors++; $display("FAIL hist_pc100: got %h expected 680", lk_index_o); end
    lk_pc_i = 32'hFFFF_2FFF; #1;
    checks++; if (lk_index_o !== 12'h1FF) begin errors++; $display("FAIL hist_pcbits: got %h expected 1ff", lk_index_o); end
  endtask

  task automatic test_ras();
    logic [31:0] expTop [3];
    expTop[0] = 32'h40; expTop[1] = 32'h30; expTop[2] = 32'h20;
    for (int i = 1; i <= 5; i++) rasOp(1'b1, 1'b0, 1'b0, 32'(i * 16));
    #1;
    checks++; if (lk_rasTop_o !== 32'h50 || lk_rasValid_o !== 1'b1) begin errors++;
      $display("FAIL ras_full: got top=%h valid=%b expected top=50 valid=1", lk_rasTop_o, lk_rasValid_o); end
    for (int i = 0; i < 3; i++) begin
      rasOp(1'b0, 1'b1, 1'b0, 32'h0);
      checks++; if (lk_rasTop_o !== expTop[i] || lk_rasValid_o !== 1'b1) begin errors++;
        $display("FAIL ras_pop%0d: got top=%h valid=%b expected top=%h valid=1", i, lk_rasTop_o, lk_rasValid_o, expTop[i]); end
    end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL ras_empty: got valid=%b expected 0", lk_rasValid_o); end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (lk_rasValid_o !== 1'b0 || lk_rasTop_o !== 32'h50) begin errors++;
      $display("FAIL ras_underflow: got top=%h valid=%b expected top=50 valid=0", lk_rasTop_o, lk_rasValid_o); end
    lk_valid_i = 1'b0; lk_isCall_i = 1'b1; lk_retAddr_i = 32'h99;
    tick(); idle();
    checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL ras_novalid: got valid=%b expected 0", lk_rasValid_o); end
  endtask

  task automatic test_coroutine();
    rasOp(1'b1, 1'b0, 1'b0, 32'h200);
    rasOp(1'b1, 1'b1, 1'b0, 32'h304);
    checks++; if (lk_rasTop_o !== 32'h304 || lk_rasValid_o !== 1'b1) begin errors++;
      $display("FAIL coro_replace: got top=%h valid=%b expected top=304 valid=1", lk_rasTop_o, lk_rasValid_o); end
    rasOp(1'b1, 1'b1, 1'b1, 32'h404);
    checks++; if (lk_rasTop_o !== 32'h304) begin errors++; $display("FAIL coro_stall: got top=%h expected 304", lk_rasTop_o); end
    rasOp(1'b0, 1'b1, 1'b1, 32'h0);
    checks++; if (lk_rasValid_o !== 1'b1) begin errors++; $display("FAIL pop_stall: got valid=%b expected 1", lk_rasValid_o); end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL coro_count: got valid=%b expected 0", lk_rasValid_o); end
    rasOp(1'b1, 1'b1, 1'b0, 32'h508);
    checks++; if (lk_rasTop_o !== 32'h508 || lk_rasValid_o !== 1'b1) begin errors++;
      $display("FAIL coro_empty: got top=%h valid=%b expected top=508 valid=1", lk_rasTop_o, lk_rasValid_o); end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (lk_rasValid_o !== 1'b0) begin errors++; $display("FAIL coro_empty_pop: got valid=%b expected 0", lk_rasValid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    addrs[0] = 32'hA0; addrs[1] = 32'hB0;
    for (int i = 0; i < 2; i++) begin
      lk_valid_i = 1'b1; lk_isCall_i = 1'b1; lk_retAddr_i = addrs[i];
      up_valid_i = 1'b1; up_index_i = 12'h123; up_taken_i = 1'b1; up_predicted_i = 1'b0;
      tick();
      histModel = {1'b1, histModel[HB-1:1]};
    end
    idle();
    lk_pc_i = pcFor(12'h123, histModel); #1;
    checks++; if (lk_rasTop_o !== 32'hB0 || lk_taken_o !== 1'b1) begin errors++;
      $display("FAIL b2b_state: got top=%h taken=%b expected top=b0 taken=1", lk_rasTop_o, lk_taken_o); end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (lk_rasTop_o !== 32'hA0 || lk_rasValid_o !== 1'b1) begin errors++;
      $display("FAIL b2b_pop: got top=%h valid=%b expected top=a0 valid=1", lk_rasTop_o, lk_rasValid_o); end
    rasOp(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_run();
    int bad;
    bad = 0;
    lk_pc_i = pcFor(12'h080, histModel); #1;
    checks++; if (lk_taken_o !== 1'b1) begin errors++; $display("FAIL pre_reset_taken: got %b expected 1", lk_taken_o); end
    rasOp(1'b1, 1'b0, 1'b0, 32'h777);
    #3 reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0 || lk_rasValid_o !== 1'b0 || lk_rasTop_o !== 32'h0) begin errors++;
      $display("FAIL async_reset: got ready=%b valid=%b top=%h expected 0/0/0", ready_o, lk_rasValid_o, lk_rasTop_o); end
    histModel = '0;
    @(negedge clk_i); reset_i = 1'b1;
    lk_pc_i = 32'h100;
    for (int c = 0; c < 100; c++) begin
      #1 if (lk_taken_o !== 1'b0 || ready_o !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reinit_gate: got %0d bad cycles expected 0", bad); end
    #3 reset_i = 1'b0;
    @(negedge clk_i); reset_i = 1'b1;
    for (int c = 1; c <= int'(INIT_CYCLES); c++) begin
      tick();
      if (c == int'(INIT_CYCLES) - 1) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reinit_early: got %b expected 0", ready_o); end
      end
    end
    #1;
    checks++; if (ready_o !== 1'b1 || lk_taken_o !== 1'b0) begin errors++;
      $display("FAIL reinit_done: got ready=%b taken=%b expected ready=1 taken=0", ready_o, lk_taken_o); end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    logic [9:0] tk, pr;
    tk = 10'b1101001110; pr = 10'b1001011100;
    for (int i = 0; i < 10; i++) doUpdate(12'h0F0, tk[i], pr[i]);
    checks++; if (stat_updates_o !== 32'd10) begin errors++; $display("FAIL stat_updates: got %0d expected 10", stat_updates_o); end
    checks++; if (stat_mispredicts_o !== 32'd3) begin errors++; $display("FAIL stat_mispredicts: got %0d expected 3", stat_mispredicts_o); end
    #3 reset_i = 1'b0;
    #1;
    checks++; if (stat_updates_o !== 32'd0 || stat_mispredicts_o !== 32'd0) begin errors++;
      $display("FAIL stat_reset: got %0d/%0d expected 0/0", stat_updates_o, stat_mispredicts_o); end
    @(negedge clk_i); reset_i = 1'b1;
    up_valid_i = 1'b1; up_taken_i = 1'b1; up_predicted_i = 1'b0;
    repeat (3) tick();
    idle();
    checks++; if (stat_updates_o !== 32'd0 || ready_o !== 1'b0) begin errors++;
      $display("FAIL stat_init: got updates=%0d ready=%b expected 0/0", stat_updates_o, ready_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_counter();
    test_history();
    test_ras();
    test_coroutine();
    test_back_to_back();
    test_reset_run();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
